// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment scanner.
// Holds segment patterns, digit index codes and the time bus width.
package seg_scan_display_pkg;

    localparam int IN_W = 15;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    typedef enum logic [1:0] {
        DIG_MSEC_L = 2'd0,
        DIG_MSEC_H = 2'd1,
        DIG_SEC_L  = 2'd2,
        DIG_SEC_H  = 2'd3
    } dig_e;

endpackage

// File: rtl/seg_scan_display_bcd_to_seg.sv
// BCD to active-low 7-segment decoder; values 10-15 show a dash.
// Ports: i_bcd (4-bit digit), o_seg (7-bit {g,f,e,d,c,b,a}, active-low).
module bcd_to_seg
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// 4-digit common-anode scanner with per-frame, stability-filtered
// snapshot of the BCD time bus and a decimal point after the seconds.
// Ports: clk_1khz, rst_n (async active-low), time_* BCD digits,
// time_out (blink request), seg_n/dp_n/an_n (active-low display),
// frame_start (one-cycle pulse on snapshot load).
// Optional: TIMEOUT_BLINK_EN blanks the display at BLINK_HALF rate
// while time_out is high.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int DIGIT_HOLD = 1,
    parameter int BLINK_HALF = 250
) (
    input  logic       clk_1khz,
    input  logic       rst_n,
    input  logic [2:0] time_sec_h,
    input  logic [3:0] time_sec_l,
    input  logic [3:0] time_msec_h,
    input  logic [3:0] time_msec_l,
    input  logic       time_out,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] an_n,
    output logic       frame_start
);

    localparam int HW = (DIGIT_HOLD > 1) ? $clog2(DIGIT_HOLD) : 1;

    logic [IN_W-1:0] w_in;
    logic [IN_W-1:0] r_stage;
    logic [IN_W-1:0] r_snap;
    logic [HW-1:0]   r_hold;
    dig_e            r_idx;
    logic            r_pend;
    logic            w_stable;
    logic            w_tc;
    logic            w_bound;
    logic            w_load;
    logic [3:0]      w_bcd;
    logic [6:0]      w_seg;
    logic            w_blank;

    assign w_in = {time_sec_h, time_sec_l,
                   time_msec_h, time_msec_l};

    // Unchanged across two consecutive samples
    assign w_stable = (w_in == r_stage);
    assign w_tc     = (r_hold == HW'(DIGIT_HOLD - 1));
    assign w_bound  = w_tc && (r_idx == DIG_SEC_H);
    // A missed boundary stays pending until the bus settles
    assign w_load   = (w_bound || r_pend) && w_stable;

    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            r_stage     <= '0;
            r_snap      <= '0;
            r_hold      <= '0;
            r_idx       <= DIG_MSEC_L;
            r_pend      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            r_stage     <= w_in;
            frame_start <= w_load;
            if (w_tc) begin
                r_hold <= '0;
                r_idx  <= dig_e'(r_idx + 2'd1);
            end else begin
                r_hold <= r_hold + HW'(1);
            end
            if (w_load) begin
                r_snap <= r_stage;
                r_pend <= 1'b0;
            end else if (w_bound) begin
                r_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        w_bcd = r_snap[3:0];
        unique case (r_idx)
            DIG_MSEC_L: w_bcd = r_snap[3:0];
            DIG_MSEC_H: w_bcd = r_snap[7:4];
            DIG_SEC_L:  w_bcd = r_snap[11:8];
            DIG_SEC_H:  w_bcd = {1'b0, r_snap[14:12]};
            default:    w_bcd = r_snap[3:0];
        endcase
    end

    bcd_to_seg u_dec (
        .i_bcd (w_bcd),
        .o_seg (w_seg)
    );

`ifdef TIMEOUT_BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;

    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (!time_out) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    // Gating with time_out un-blanks on the very next edge after a drop
    assign w_blank = time_out && !r_phase;
`else
    logic w_unused_blink;

    assign w_unused_blink = time_out & (BLINK_HALF > 0);
    assign w_blank        = 1'b0;
`endif

    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            seg_n <= SEG_OFF;
            dp_n  <= 1'b1;
            an_n  <= 4'hF;
        end else if (w_blank) begin
            seg_n <= SEG_OFF;
            dp_n  <= 1'b1;
            an_n  <= 4'hF;
        end else begin
            seg_n <= w_seg;
            dp_n  <= (r_idx != DIG_SEC_L);
            an_n  <= ~(4'b0001 << r_idx);
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed self-checking bench for seg_scan_display.
// Covers reset, scan order, dash decoding, stability deferral and blink.
module tb_seg_scan_display;

    logic       clk_1khz;
    logic       rst_n;
    logic [2:0] time_sec_h;
    logic [3:0] time_sec_l;
    logic [3:0] time_msec_h;
    logic [3:0] time_msec_l;
    logic       time_out;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;
    logic       frame_start;

    int n_vec;
    int n_err;

    seg_scan_display #(
        .DIGIT_HOLD (1),
        .BLINK_HALF (4)
    ) dut (
        .clk_1khz    (clk_1khz),
        .rst_n       (rst_n),
        .time_sec_h  (time_sec_h),
        .time_sec_l  (time_sec_l),
        .time_msec_h (time_msec_h),
        .time_msec_l (time_msec_l),
        .time_out    (time_out),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    initial clk_1khz = 1'b0;
    always #5 clk_1khz = ~clk_1khz;

    task automatic step();
        @(posedge clk_1khz);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_vec++;
        if ({seg_n, dp_n, an_n, frame_start} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            n_err++;
            $display("FAIL reset_hold: seg=%h dp=%b an=%h fs=%b, want 7f 1 f 0",
                     seg_n, dp_n, an_n, frame_start);
        end
        rst_n = 1'b1;
        step();
        // Snapshot is zero after reset: 00.00 shown in full
        n_vec++;
        if ({seg_n, dp_n, an_n, frame_start} !== {7'h40, 1'b1, 4'hE, 1'b0}) begin
            n_err++;
            $display("FAIL reset_first_digit: seg=%h dp=%b an=%h fs=%b, want 40 1 e 0",
                     seg_n, dp_n, an_n, frame_start);
        end
        step();
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({seg_n, dp_n, an_n, frame_start} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            n_err++;
            $display("FAIL reset_async: seg=%h dp=%b an=%h fs=%b, want 7f 1 f 0",
                     seg_n, dp_n, an_n, frame_start);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_scan_order();
        logic [3:0] e_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [6:0] e_seg [4] = '{7'h10, 7'h10, 7'h10, 7'h12};
        logic       e_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        bit got;
        time_sec_h  = 3'd5;
        time_sec_l  = 4'd9;
        time_msec_h = 4'd9;
        time_msec_l = 4'd9;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (frame_start) got = 1;
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL scan_frame_wait: frame_start=0 for 20 cycles, want 1");
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if ({an_n, seg_n, dp_n} !== {e_an[i], e_seg[i], e_dp[i]}) begin
                n_err++;
                $display("FAIL scan_digit%0d: an=%h seg=%b dp=%b, want %h %b %b",
                         i, an_n, seg_n, dp_n, e_an[i], e_seg[i], e_dp[i]);
            end
        end
    endtask

    task automatic test_invalid_bcd();
        logic [3:0] e_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [6:0] e_seg [4] = '{7'h3F, 7'h10, 7'h10, 7'h12};
        logic       e_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        bit got;
        time_msec_l = 4'hC;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (frame_start) got = 1;
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL dash_frame_wait: frame_start=0 for 20 cycles, want 1");
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if ({an_n, seg_n, dp_n} !== {e_an[i], e_seg[i], e_dp[i]}) begin
                n_err++;
                $display("FAIL dash_digit%0d: an=%h seg=%b dp=%b, want %h %b %b",
                         i, an_n, seg_n, dp_n, e_an[i], e_seg[i], e_dp[i]);
            end
        end
    endtask

    task automatic test_stability();
        bit got;
        int seen;
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            time_msec_l = (i % 2 == 0) ? 4'd1 : 4'd2;
            step();
            if (frame_start) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL stab_toggle: %0d frame_start pulses, want 0", seen);
        end
        time_msec_l = 4'd3;
        step();
        n_vec++;
        if (frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL stab_first_hold: fs=%b, want 0", frame_start);
        end
        step();
        n_vec++;
        if (frame_start !== 1'b1) begin
            n_err++;
            $display("FAIL stab_load: fs=%b, want 1", frame_start);
        end
        got = 0;
        for (int k = 0; k < 6 && !got; k++) begin
            step();
            if (an_n == 4'hE) got = 1;
        end
        n_vec++;
        if (!got || seg_n !== 7'h30) begin
            n_err++;
            $display("FAIL stab_digit0: an=%h seg=%b, want e 0110000", an_n, seg_n);
        end
    endtask

    task automatic test_blink();
        bit exp_blank;
        bit bad;
        bad = 0;
        time_out = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
`ifdef TIMEOUT_BLINK_EN
            exp_blank = ((i / 4) % 2) == 1;
`else
            exp_blank = 1'b0;
`endif
            n_vec++;
            if (exp_blank) begin
                if ({an_n, seg_n, dp_n} !== {4'hF, 7'h7F, 1'b1}) begin
                    n_err++;
                    bad = 1;
                    $display("FAIL blink_off_%0d: an=%h seg=%h dp=%b, want f 7f 1",
                             i, an_n, seg_n, dp_n);
                end
            end else if (!(an_n inside {4'hE, 4'hD, 4'hB, 4'h7})) begin
                n_err++;
                bad = 1;
                $display("FAIL blink_on_%0d: an=%h, want one-hot-low digit", i, an_n);
            end
        end
        time_out = 1'b0;
        step();
        n_vec++;
        if (!(an_n inside {4'hE, 4'hD, 4'hB, 4'h7})) begin
            n_err++;
            $display("FAIL blink_release: an=%h, want one-hot-low digit", an_n);
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        time_sec_h  = '0;
        time_sec_l  = '0;
        time_msec_h = '0;
        time_msec_l = '0;
        time_out    = 1'b0;
        test_reset();
        test_scan_order();
        test_invalid_bcd();
        test_stability();
        test_blink();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
